// File: rtl/f2s_stream_pkg.sv
// Shared types and constants for the FPGA-to-HPS stream writer.
// The optional 4 KiB burst guard is selected by F2S_STREAM_WR_4K_GUARD_EN.
package f2s_stream_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_WRITE  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam int BURST_MAX_DEFAULT = 16;
   localparam int BYTES_PER_WORD    = 4;

endpackage

// File: rtl/f2s_burst_sizer.sv
// Burst length selection: min(BURST_MAX, remaining), optionally clipped so a
// burst never crosses a 4 KiB page when F2S_STREAM_WR_4K_GUARD_EN is defined.
module f2s_burst_sizer
   import f2s_stream_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
   input  logic [LEN_W-1:0] remaining,
   input  logic [31:0]      address,
   output logic [7:0]       burst_len
);

   logic [31:0] rem_ext;
   logic [31:0] limit;

`ifdef F2S_STREAM_WR_4K_GUARD_EN
   logic [31:0] page_words;
   logic        unused_addr;

   // Words left before the next 4 KiB boundary: 1..1024.
   assign page_words  = 32'd1024 - {22'd0, address[11:2]};
   assign unused_addr = &{1'b0, address[31:12], address[1:0]};

   always_comb begin
      rem_ext = 32'(remaining);
      limit   = 32'(BURST_MAX);
      if (page_words < limit) limit = page_words;
      burst_len = (rem_ext < limit) ? rem_ext[7:0] : limit[7:0];
   end
`else
   logic unused_addr;

   assign unused_addr = &{1'b0, address};

   always_comb begin
      rem_ext   = 32'(remaining);
      limit     = 32'(BURST_MAX);
      burst_len = (rem_ext < limit) ? rem_ext[7:0] : limit[7:0];
   end
`endif

endmodule

// File: rtl/f2s_stream_writer.sv
// Streams buf_len words from a valid/ready sink into HPS memory as Avalon-MM
// write bursts. Define F2S_STREAM_WR_4K_GUARD_EN to keep bursts inside 4 KiB pages.
module f2s_stream_writer
   import f2s_stream_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [31:0]         buf_addr,
   input  logic [LEN_W-1:0]    buf_len,
   input  logic                start,
   input  logic [DATA_W-1:0]   snk_data,
   input  logic                snk_valid,
   output logic                snk_ready,
   output logic [31:0]         avm_address,
   output logic [7:0]          avm_burstcount,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    words_done
);

   state_t           state_q, state_d;
   logic [31:0]      addr_q;
   logic [7:0]       burstcount_q;
   logic [7:0]       beat_q;
   logic [LEN_W-1:0] remaining_q;
   logic [LEN_W-1:0] words_done_q;
   logic             zero_done_q;
   logic [7:0]       burst_len;
   logic             beat;
   logic             last_beat;
   logic             launch;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, buf_addr[1:0]};

   f2s_burst_sizer #(
      .LEN_W     (LEN_W),
      .BURST_MAX (BURST_MAX)
   ) u_sizer (
      .remaining (remaining_q),
      .address   (addr_q),
      .burst_len (burst_len)
   );

   assign launch    = (state_q == S_IDLE) && start;
   assign beat      = (state_q == S_WRITE) && snk_valid && !avm_waitrequest;
   assign last_beat = beat && (beat_q == 8'd1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (launch && (buf_len != '0)) state_d = S_SETUP;
         S_SETUP:  state_d = S_WRITE;
         S_WRITE:  if (last_beat) state_d = (remaining_q != LEN_W'(1)) ? S_SETUP : S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Sink and master are tied straight together; ready never depends on valid.
   always_comb begin
      avm_write = (state_q == S_WRITE) && snk_valid;
      snk_ready = (state_q == S_WRITE) && !avm_waitrequest;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FINISH) || zero_done_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q       <= '0;
         burstcount_q <= '0;
         beat_q       <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         zero_done_q  <= 1'b0;
      end else begin
         zero_done_q <= launch && (buf_len == '0);
         if (launch && (buf_len != '0)) begin
            addr_q       <= {buf_addr[31:2], 2'b00};
            remaining_q  <= buf_len;
            words_done_q <= '0;
         end
         if (state_q == S_SETUP) begin
            burstcount_q <= burst_len;
            beat_q       <= burst_len;
         end
         if (beat) begin
            beat_q       <= beat_q - 8'd1;
            remaining_q  <= remaining_q - LEN_W'(1);
            words_done_q <= words_done_q + LEN_W'(1);
         end
         // Address advances once per burst; wraps naturally at 2^32.
         if (last_beat) addr_q <= addr_q + 32'(burstcount_q) * 32'(BYTES_PER_WORD);
      end
   end

   assign avm_address    = addr_q;
   assign avm_burstcount = burstcount_q;
   assign avm_writedata  = snk_data;
   assign avm_byteenable = '1;
   assign words_done     = words_done_q;

endmodule

// File: tb/tb_f2s_stream_writer.sv
// Scoreboard bench for f2s_stream_writer; burst expectations follow
// F2S_STREAM_WR_4K_GUARD_EN when the bench is built with it.
module tb_f2s_stream_writer;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   typedef struct {
      logic [31:0] addr;
      int          len;
   } burst_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [31:0]       buf_addr = '0;
   logic [LEN_W-1:0]  buf_len = '0;
   logic              start = 1'b0;
   logic [DATA_W-1:0] snk_data = '0;
   logic              snk_valid = 1'b0;
   logic              snk_ready;
   logic [31:0]       avm_address;
   logic [7:0]        avm_burstcount;
   logic              avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest = 1'b0;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  words_done;

   f2s_stream_writer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_MAX(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .buf_addr        (buf_addr),
      .buf_len         (buf_len),
      .start           (start),
      .snk_data        (snk_data),
      .snk_valid       (snk_valid),
      .snk_ready       (snk_ready),
      .avm_address     (avm_address),
      .avm_burstcount  (avm_burstcount),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .words_done      (words_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DATA_W-1:0] exp_data[$];
   burst_t            exp_bursts[$];
   burst_t            burst_log[$];
   logic [DATA_W-1:0] src_data[$];
   int                src_idx = 0;
   int                pushed = 0;
   bit                stall_en = 1'b0;
   bit                gap_en = 1'b0;
   bit                acc = 1'b0;
   bit                took;
   int                done_cnt = 0;
   int                total_beats = 0;
   int                beat_in_burst = 0;
   logic [31:0]       cur_addr = '0;
   logic [7:0]        cur_len = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference burst split: page-clipped only when the guard is built in.
   task automatic build_bursts(input logic [31:0] addr, input int len);
      logic [31:0] a;
      int          rem, n, lim;
      a   = {addr[31:2], 2'b00};
      rem = len;
      while (rem > 0) begin
         n = (rem < 16) ? rem : 16;
`ifdef F2S_STREAM_WR_4K_GUARD_EN
         lim = (4096 - int'(a[11:0])) / 4;
         if (lim < n) n = lim;
`else
         lim = n;
`endif
         exp_bursts.push_back('{a, n});
         a   = a + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   // Source driver: holds a word until accepted, pushes it to the scoreboard when first offered.
   always @(posedge clk) begin
      #1;
      avm_waitrequest = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
      took = acc;
      acc  = 1'b0;
      if (took) src_idx++;
      if (!(snk_valid && !took)) begin
         if (src_idx < src_data.size()) begin
            snk_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            snk_data  = src_data[src_idx];
            if (snk_valid && src_idx == pushed) begin
               exp_data.push_back(snk_data);
               pushed++;
            end
         end else begin
            snk_valid = 1'b0;
         end
      end
   end

   // Monitor: checks every accepted beat and burst header against the scoreboard.
   always @(negedge clk) begin
      acc = snk_valid && snk_ready;
      if (reset_n) begin
         if (done) done_cnt++;
         if (!busy) begin
            check("idle_write", avm_write, 1'b0);
            check("idle_ready", snk_ready, 1'b0);
         end
         if (avm_write && beat_in_burst != 0) begin
            check("addr_stable", avm_address, cur_addr);
            check("bc_stable", avm_burstcount, cur_len);
         end
         if (avm_write && !avm_waitrequest) begin
            if (beat_in_burst == 0) begin
               if (exp_bursts.size() == 0) check("burst_unexpected", 1, 0);
               else begin
                  burst_t b;
                  b = exp_bursts.pop_front();
                  check("burst_addr", avm_address, b.addr);
                  check("burst_len", avm_burstcount, b.len);
               end
               cur_addr = avm_address;
               cur_len  = avm_burstcount;
               burst_log.push_back('{avm_address, int'(avm_burstcount)});
            end
            if (exp_data.size() == 0) check("data_unexpected", 1, 0);
            else check("data", avm_writedata, exp_data.pop_front());
            check("byteenable", avm_byteenable, 4'hF);
            beat_in_burst++;
            total_beats++;
            if (beat_in_burst >= int'(cur_len)) beat_in_burst = 0;
         end
      end
   end

   task automatic load_source(input int len);
      src_data.delete();
      for (int i = 0; i < len; i++) src_data.push_back($urandom);
      src_idx = 0;
      pushed  = 0;
   endtask

   task automatic run_xfer(input logic [31:0] addr, input int len,
                           input bit stall, input bit gap, input bit intrude);
      int d0, b0, cyc;
      burst_log.delete();
      load_source(len);
      build_bursts(addr, len);
      stall_en = stall;
      gap_en   = gap;
      d0 = done_cnt;
      b0 = total_beats;
      @(posedge clk); #1;
      buf_addr = addr;
      buf_len  = LEN_W'(len);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (intrude && cyc == 12) begin
            check("busy_at_intrude", busy, 1'b1);
            @(posedge clk); #1;
            buf_addr = 32'h5000_0000;
            buf_len  = LEN_W'(3);
            start    = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      if (cyc >= 3000) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      stall_en = 1'b0;
      check("done_pulses", done_cnt - d0, 1);
      check("beat_count", total_beats - b0, len);
      check("words_done", words_done, len);
      check("busy_after", busy, 1'b0);
      check("data_left", exp_data.size(), 0);
      check("bursts_left", exp_bursts.size(), 0);
   endtask

   initial begin
      int b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_write", avm_write, 1'b0);
      check("rst_ready", snk_ready, 1'b0);
      check("rst_addr", avm_address, 32'h0);
      check("rst_bc", avm_burstcount, 8'h0);
      check("rst_words", words_done, 16'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Three bursts, no stalls.
      run_xfer(32'h2000_0000, 40, 1'b0, 1'b0, 1'b0);
      check("l40_n", burst_log.size(), 3);
      if (burst_log.size() == 3) begin
         check("l40_a0", burst_log[0].addr, 32'h2000_0000);
         check("l40_n0", burst_log[0].len, 16);
         check("l40_a1", burst_log[1].addr, 32'h2000_0040);
         check("l40_n1", burst_log[1].len, 16);
         check("l40_a2", burst_log[2].addr, 32'h2000_0080);
         check("l40_n2", burst_log[2].len, 8);
      end

      // Transfer straddling a 4 KiB boundary.
      run_xfer(32'h0000_0FF8, 8, 1'b0, 1'b0, 1'b0);
`ifdef F2S_STREAM_WR_4K_GUARD_EN
      check("pg_n", burst_log.size(), 2);
      if (burst_log.size() == 2) begin
         check("pg_a0", burst_log[0].addr, 32'h0000_0FF8);
         check("pg_n0", burst_log[0].len, 2);
         check("pg_a1", burst_log[1].addr, 32'h0000_1000);
         check("pg_n1", burst_log[1].len, 6);
      end
`else
      check("pg_n", burst_log.size(), 1);
      if (burst_log.size() == 1) begin
         check("pg_a0", burst_log[0].addr, 32'h0000_0FF8);
         check("pg_n0", burst_log[0].len, 8);
      end
`endif

      // Random stalls and source gaps.
      run_xfer(32'h1000_0F80, 33, 1'b1, 1'b1, 1'b0);

      // Start while busy must be ignored.
      run_xfer(32'h4000_0000, 40, 1'b1, 1'b0, 1'b1);
      if (burst_log.size() > 0) check("intr_a0", burst_log[0].addr, 32'h4000_0000);
      check("intr_bursts", burst_log.size(), 3);

      // Address wrap and ignored low address bits.
      run_xfer(32'hFFFF_FFC2, 32, 1'b0, 1'b1, 1'b0);
      if (burst_log.size() > 1) check("wrap_a1", burst_log[1].addr, 32'h0000_0000);

      // Zero-length start.
      b0 = total_beats;
      @(posedge clk); #1;
      buf_addr = 32'h6000_0000;
      buf_len  = '0;
      start    = 1'b1;
      @(negedge clk);
      check("zl_done_early", done, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("zl_done", done, 1'b1);
      check("zl_busy", busy, 1'b0);
      @(negedge clk);
      check("zl_done_off", done, 1'b0);
      check("zl_no_write", total_beats - b0, 0);

      // Reset during the 5th beat of a 16-beat burst.
      load_source(16);
      build_bursts(32'h1000_0000, 16);
      b0 = total_beats;
      @(posedge clk); #1;
      buf_addr = 32'h1000_0000;
      buf_len  = LEN_W'(16);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200 && (total_beats - b0) < 4; i++) @(negedge clk);
      check("rst_mid_beats", total_beats - b0, 4);
      @(posedge clk); #3;
      check("rst_mid_pre", avm_write, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rstm_write", avm_write, 1'b0);
      check("rstm_ready", snk_ready, 1'b0);
      check("rstm_busy", busy, 1'b0);
      check("rstm_done", done, 1'b0);
      check("rstm_addr", avm_address, 32'h0);
      check("rstm_bc", avm_burstcount, 8'h0);
      check("rstm_words", words_done, 16'h0);
      src_data.delete();
      exp_data.delete();
      exp_bursts.delete();
      src_idx = 0;
      pushed  = 0;
      snk_valid = 1'b0;
      acc = 1'b0;
      beat_in_burst = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run_xfer(32'h3000_0000, 4, 1'b0, 1'b0, 1'b0);
      check("post_rst_n", burst_log.size(), 1);
      if (burst_log.size() == 1) begin
         check("post_rst_a", burst_log[0].addr, 32'h3000_0000);
         check("post_rst_len", burst_log[0].len, 4);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/f2s_stream_writer.md
F2S_STREAM_WRITER -- requirements
Module: f2s_stream_writer

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits of the sink stream and of avm_writedata.
REQ-002 Parameter LEN_W, default 16: width of the transfer length in words.
REQ-003 Parameter BURST_MAX, default 16: maximum Avalon burstcount, a power of two from 1 to 128.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 buf_addr  input  32  HPS byte base address, driven by the stream buffer address PIO register; bits [1:0] ignored.
REQ-007 buf_len  input  LEN_W  number of words to transfer; 0 means no transfer.
REQ-008 start  input  1  single-cycle pulse that launches a transfer; ignored while busy.
REQ-009 snk_data  input  DATA_W  stream data word.
REQ-010 snk_valid  input  1  snk_data is valid.
REQ-011 snk_ready  output  1  writer accepts snk_data this cycle.
REQ-012 avm_address  output  32  byte address of the current burst.
REQ-013 avm_burstcount  output  8  length of the current burst in words.
REQ-014 avm_write  output  1  Avalon write request.
REQ-015 avm_writedata  output  DATA_W  write data.
REQ-016 avm_byteenable  output  DATA_W/8  byte enables; all ones.
REQ-017 avm_waitrequest  input  1  slave stall.
REQ-018 busy  output  1  transfer in progress.
REQ-019 done  output  1  one-cycle pulse when the final word is accepted by the slave.
REQ-020 words_done  output  LEN_W  count of words accepted in the current or last transfer.

Function
REQ-021 The state machine SHALL have the states IDLE, SETUP, WRITE and FINISH.
REQ-022 IDLE with start=1 and buf_len!=0: latch {buf_addr[31:2],2'b00} into the address register, latch buf_len into the remaining counter, clear words_done, go to SETUP.
REQ-023 IDLE with start=1 and buf_len=0: pulse done the next cycle; busy stays 0.
REQ-024 SETUP (one cycle): burst length = min(BURST_MAX, remaining), further limited per REQ-036; load the per-burst beat counter; go to WRITE.
REQ-025 WRITE: avm_write=snk_valid; avm_writedata=snk_data; snk_ready=~avm_waitrequest; a beat completes when snk_valid & ~avm_waitrequest.
REQ-026 avm_address and avm_burstcount SHALL be held constant from the first beat to the last beat of a burst.
REQ-027 Each completed beat decrements the beat counter and the remaining counter and increments words_done.
REQ-028 On the last beat of a burst: address += 4*burstlen; go to SETUP if remaining>0 after this beat, otherwise go to FINISH.
REQ-029 FINISH: pulse done for one cycle, return to IDLE.
REQ-030 busy=1 in SETUP, WRITE and FINISH.
REQ-031 A start pulse while busy SHALL be ignored, with no change to the latched parameters.
REQ-032 Address arithmetic SHALL wrap modulo 2^32.
REQ-033 snk_ready=0 and avm_write=0 outside WRITE; there is no combinational path from snk_valid to snk_ready.

Reset
REQ-034 reset_n low, asynchronous and at any time including mid-burst: state IDLE; avm_write, snk_ready, busy, done = 0; avm_address, avm_burstcount, words_done = 0; the partial burst is abandoned.

Configuration
REQ-035 The macro F2S_STREAM_WR_4K_GUARD_EN SHALL select 4 KiB boundary handling.
REQ-036 With F2S_STREAM_WR_4K_GUARD_EN defined, the burst length SHALL additionally be limited to (4096 - address[11:0])/4 so that no burst crosses a 4 KiB boundary.
REQ-037 Without F2S_STREAM_WR_4K_GUARD_EN, the burst length SHALL be min(BURST_MAX, remaining) only.

Structure
REQ-038 Package f2s_stream_pkg SHALL hold the state enum type, the BURST_MAX default and the byte-per-word constant.
REQ-039 Sub-module f2s_burst_sizer SHALL compute the burst length from remaining, address and the macro option; all other logic is flat.

Verification
REQ-040 buf_addr=0x2000_0000, buf_len=40, BURST_MAX=16, no stalls: bursts of 16/16/8 at addresses 0x2000_0000/0x2000_0040/0x2000_0080; done pulses once; words_done=40.
REQ-041 buf_addr=0x0000_0FF8, buf_len=8, macro defined: bursts of 2 at 0xFF8 and 6 at 0x1000. Same stimulus without the macro: one burst of 8 at 0xFF8.
REQ-042 Random waitrequest and snk_valid gaps, buf_len=33: 33 beats written in order with no dropped or duplicated data; address and burstcount stable within each burst.
REQ-043 buf_len=0 with start: done pulses one cycle later; no avm_write is issued.
REQ-044 Assert reset_n low at the 5th beat of a 16-beat burst: all outputs reset within the same cycle; a new start at 0x3000_0000 with buf_len=4 completes normally.
REQ-045 A second start mid-transfer with a different buf_addr: ignored; the original transfer completes unchanged.
